// File: rtl/c64_kbd_pkg.sv
// Shared types and constants for the C64 keyboard matrix front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: parser state enum, PS/2 set-2 prefix bytes, matrix position type
// and a small constructor for ROM entries.
package c64_kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXTBRK,
    SKIP
  } kbd_state_t;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  // Pause/Break sends E1 followed by seven more bytes carrying no key state.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // a = CIA1 port A line, b = CIA1 port B line.
  typedef struct packed {
    logic       valid;
    logic [2:0] a;
    logic [2:0] b;
  } key_pos_t;

  function automatic key_pos_t kp(input int a, input int b);
    key_pos_t p;
    p.valid = 1'b1;
    p.a     = 3'(a);
    p.b     = 3'(b);
    return p;
  endfunction

endpackage

// File: rtl/c64_keymap.sv
// PS/2 set-2 scan code to C64 matrix position ROM.
// Latency: combinational.
// Backpressure: none.
//
// Ports: ext  - code was E0-prefixed
//        code - PS/2 scan code byte
//        pos  - matrix position, valid=0 for unmapped codes
module c64_keymap
  import c64_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_pos_t   pos
);

  always_comb begin
    pos = '0;
    case ({ext, code})
      // PA0: DEL RETURN CRSR-R F7 F1 F3 F5 CRSR-D
      9'h066: pos = kp(0, 0);
      9'h05A: pos = kp(0, 1);
      9'h174: pos = kp(0, 2);
      9'h083: pos = kp(0, 3);
      9'h005: pos = kp(0, 4);
      9'h004: pos = kp(0, 5);
      9'h003: pos = kp(0, 6);
      9'h172: pos = kp(0, 7);
      // PA1: 3 W A 4 Z S E LSHIFT
      9'h026: pos = kp(1, 0);
      9'h01D: pos = kp(1, 1);
      9'h01C: pos = kp(1, 2);
      9'h025: pos = kp(1, 3);
      9'h01A: pos = kp(1, 4);
      9'h01B: pos = kp(1, 5);
      9'h024: pos = kp(1, 6);
      9'h012: pos = kp(1, 7);
      // PA2: 5 R D 6 C F T X
      9'h02E: pos = kp(2, 0);
      9'h02D: pos = kp(2, 1);
      9'h023: pos = kp(2, 2);
      9'h036: pos = kp(2, 3);
      9'h021: pos = kp(2, 4);
      9'h02B: pos = kp(2, 5);
      9'h02C: pos = kp(2, 6);
      9'h022: pos = kp(2, 7);
      // PA3: 7 Y G 8 B H U V
      9'h03D: pos = kp(3, 0);
      9'h035: pos = kp(3, 1);
      9'h034: pos = kp(3, 2);
      9'h03E: pos = kp(3, 3);
      9'h032: pos = kp(3, 4);
      9'h033: pos = kp(3, 5);
      9'h03C: pos = kp(3, 6);
      9'h02A: pos = kp(3, 7);
      // PA4: 9 I J 0 M K O N
      9'h046: pos = kp(4, 0);
      9'h043: pos = kp(4, 1);
      9'h03B: pos = kp(4, 2);
      9'h045: pos = kp(4, 3);
      9'h03A: pos = kp(4, 4);
      9'h042: pos = kp(4, 5);
      9'h044: pos = kp(4, 6);
      9'h031: pos = kp(4, 7);
      // PA5: + P L - . : @ ,   (+ on keypad, : on apostrophe, @ on [)
      9'h079: pos = kp(5, 0);
      9'h04D: pos = kp(5, 1);
      9'h04B: pos = kp(5, 2);
      9'h04E: pos = kp(5, 3);
      9'h049: pos = kp(5, 4);
      9'h052: pos = kp(5, 5);
      9'h054: pos = kp(5, 6);
      9'h041: pos = kp(5, 7);
      // PA6: pound * ; HOME RSHIFT = up-arrow /   (pound on \, * on ], up on F9)
      9'h05D: pos = kp(6, 0);
      9'h05B: pos = kp(6, 1);
      9'h04C: pos = kp(6, 2);
      9'h16C: pos = kp(6, 3);
      9'h059: pos = kp(6, 4);
      9'h055: pos = kp(6, 5);
      9'h001: pos = kp(6, 6);
      9'h04A: pos = kp(6, 7);
      // PA7: 1 left-arrow CTRL 2 SPACE C= Q RUN/STOP   (left-arrow on `)
      9'h016: pos = kp(7, 0);
      9'h00E: pos = kp(7, 1);
      9'h00D: pos = kp(7, 2);
      9'h01E: pos = kp(7, 3);
      9'h029: pos = kp(7, 4);
      9'h011: pos = kp(7, 5);
      9'h015: pos = kp(7, 6);
      9'h076: pos = kp(7, 7);
      default: pos = '0;
    endcase
  end

endmodule

// File: rtl/c64_keymatrix.sv
// PS/2 set-2 byte stream to C64 keyboard matrix, RESTORE line and CIA1 port resolution.
// Latency: key state updates on the strobe edge; pa_in/pb_in/key_any one clk later.
// Backpressure: none; every ps2_valid byte is consumed (dropped only under kbd_clear).
//
// Ports: ps2_valid/ps2_data - byte strobe from PS/2 receiver
//        kbd_clear          - release all keys and RESTORE, abandon any prefix
//        pa_out/pb_out      - CIA1 port drives (0 = line pulled low)
//        joy1_n/joy2_n      - joysticks onto PB[4:0]/PA[4:0], active low
//        pa_in/pb_in        - resolved port levels back to CIA1
//        restore_n          - RESTORE key, active low
//        key_any            - any matrix key held
module c64_keymatrix
  import c64_kbd_pkg::*;
#(
  parameter int         PREFIX_TIMEOUT = 1000000,
  parameter logic [7:0] RESTORE_CODE   = 8'h7D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic       kbd_clear,
  input  logic [7:0] pa_out,
  input  logic [7:0] pb_out,
  input  logic [4:0] joy1_n,
  input  logic [4:0] joy2_n,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n,
  output logic       key_any
);

  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);

  kbd_state_t    state;
  logic [2:0]    skip_cnt;
  logic [TW-1:0] to_cnt;
  logic [63:0]   key;

  logic          ext_sel;
  logic          is_restore;
  key_pos_t      pos;

  // The ROM is addressed by the incoming byte directly; the extended flag
  // comes from the prefix already seen.
  assign ext_sel    = (state == EXT) || (state == EXTBRK);
  assign is_restore = ext_sel && (ps2_data == RESTORE_CODE);

  c64_keymap u_keymap (
    .ext  (ext_sel),
    .code (ps2_data),
    .pos  (pos)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      to_cnt    <= '0;
      key       <= '0;
      restore_n <= 1'b1;
    end else if (kbd_clear) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      to_cnt    <= '0;
      key       <= '0;
      restore_n <= 1'b1;
    end else if (ps2_valid) begin
      to_cnt <= '0;
      case (state)
        IDLE: begin
          if (ps2_data == PS2_BRK) begin
            state <= BRK;
          end else if (ps2_data == PS2_EXT) begin
            state <= EXT;
          end else if (ps2_data == PS2_PAUSE) begin
            state    <= SKIP;
            skip_cnt <= PAUSE_SKIP;
          end else if (ps2_data == PS2_BAT_OK || ps2_data == PS2_ERR_LO ||
                       ps2_data == PS2_ERR_HI) begin
            // Keyboard self-test or error: nothing it reported is trustworthy.
            key <= '0;
          end else if (pos.valid) begin
            key[{pos.a, pos.b}] <= 1'b1;
          end
        end
        BRK: begin
          if (pos.valid) key[{pos.a, pos.b}] <= 1'b0;
          state <= IDLE;
        end
        EXT: begin
          if (ps2_data == PS2_BRK) begin
            state <= EXTBRK;
          end else if (ps2_data != PS2_EXT) begin
            // A repeated E0 keeps the prefix pending.
            if (is_restore)     restore_n <= 1'b0;
            else if (pos.valid) key[{pos.a, pos.b}] <= 1'b1;
            state <= IDLE;
          end
        end
        EXTBRK: begin
          if (is_restore)     restore_n <= 1'b1;
          else if (pos.valid) key[{pos.a, pos.b}] <= 1'b0;
          state <= IDLE;
        end
        SKIP: begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      // A prefix with no follow-up byte (e.g. a glitched stream) must not
      // reinterpret the next keystroke much later.
      if (to_cnt == TO_LAST) begin
        state  <= IDLE;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Port resolution: a held key shorts its PA and PB lines, so a line driven
  // low on one side pulls the other side low. Single hop only.
  logic [7:0] pa_nxt;
  logic [7:0] pb_nxt;

  always_comb begin
    pa_nxt = pa_out & {3'b111, joy2_n};
    pb_nxt = pb_out & {3'b111, joy1_n};
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        if (key[a*8+b]) begin
          if (!pa_out[a]) pb_nxt[b] = 1'b0;
          if (!pb_out[b]) pa_nxt[a] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_in   <= 8'hFF;
      pb_in   <= 8'hFF;
      key_any <= 1'b0;
    end else begin
      pa_in   <= pa_nxt;
      pb_in   <= pb_nxt;
      key_any <= |key;
    end
  end

endmodule

// File: tb/tb_c64_keymatrix.sv
// Directed bench for c64_keymatrix: stimulus pushes hand-computed expected
// outputs into a scoreboard queue; a monitor pops and compares on each check strobe.
module tb_c64_keymatrix;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_valid;
  logic [7:0] ps2_data;
  logic       kbd_clear;
  logic [7:0] pa_out;
  logic [7:0] pb_out;
  logic [4:0] joy1_n;
  logic [4:0] joy2_n;
  logic [7:0] pa_in;
  logic [7:0] pb_in;
  logic       restore_n;
  logic       key_any;

  c64_keymatrix #(.PREFIX_TIMEOUT(TO), .RESTORE_CODE(8'h7D)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_valid (ps2_valid),
    .ps2_data  (ps2_data),
    .kbd_clear (kbd_clear),
    .pa_out    (pa_out),
    .pb_out    (pb_out),
    .joy1_n    (joy1_n),
    .joy2_n    (joy2_n),
    .pa_in     (pa_in),
    .pb_in     (pb_in),
    .restore_n (restore_n),
    .key_any   (key_any)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pa;
    logic [7:0] pb;
    logic       rn;
    logic       ka;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  logic  chk_vld = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Monitor: compares whenever the stimulus side flags a sample point.
  always @(negedge clk) begin
    if (chk_vld) begin
      exp_t  e;
      exp_t  g;
      string nm;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry, required one");
      end else begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        g  = '{pa: pa_in, pb: pb_in, rn: restore_n, ka: key_any};
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s: got pa_in=%h pb_in=%h restore_n=%b key_any=%b, required pa_in=%h pb_in=%h restore_n=%b key_any=%b",
                   nm, g.pa, g.pb, g.rn, g.ka, e.pa, e.pb, e.rn, e.ka);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    ps2_valid = 1'b1;
    ps2_data  = d;
    @(posedge clk); #1;
    ps2_valid = 1'b0;
    ps2_data  = 8'h00;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  // Two edges cover the key update plus the registered port/key_any stage.
  task automatic expect_out(input string nm, input logic [7:0] pa, input logic [7:0] pb,
                            input logic rn, input logic ka);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{pa: pa, pb: pb, rn: rn, ka: ka});
    nm_q.push_back(nm);
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ps2_valid = 1'b0; ps2_data = 8'h00; kbd_clear = 1'b0;
    pa_out = 8'h00; pb_out = 8'h00; joy1_n = 5'h1F; joy2_n = 5'h1F;
    expect_out("reset_values", 8'hFF, 8'hFF, 1'b1, 1'b0);
    pa_out = 8'hFF; pb_out = 8'hFF;
    @(posedge clk); #1 reset = 1'b0;
    expect_out("idle_after_reset", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Forward path: A at (1,2)
    send(8'h1C);
    pa_out = 8'hFE;
    expect_out("a_pa0_low", 8'hFE, 8'hFF, 1'b1, 1'b1);
    pa_out = 8'hFD;
    expect_out("a_pa1_low", 8'hFD, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hF0, 8'h1C});
    expect_out("a_break", 8'hFD, 8'hFF, 1'b1, 1'b0);

    // Reverse path and joystick merge
    send(8'h1C);
    pa_out = 8'hFF; pb_out = 8'hFB;
    expect_out("a_reverse", 8'hFD, 8'hFB, 1'b1, 1'b1);
    joy2_n = 5'h1E;
    expect_out("a_reverse_joy2", 8'hFC, 8'hFB, 1'b1, 1'b1);
    joy2_n = 5'h1F; pb_out = 8'hFF;
    send_seq('{8'hF0, 8'h1C});
    joy1_n = 5'h0F;
    expect_out("joy1_fire", 8'hFF, 8'hEF, 1'b1, 1'b0);
    joy1_n = 5'h1F;

    // RESTORE never touches the matrix
    pa_out = 8'h00;
    send_seq('{8'hE0, 8'h7D});
    expect_out("restore_make", 8'h00, 8'hFF, 1'b0, 1'b0);
    send_seq('{8'hE0, 8'hF0, 8'h7D});
    expect_out("restore_break", 8'h00, 8'hFF, 1'b1, 1'b0);

    // Extended CRSR-R (0,2), with a repeated E0 prefix
    pa_out = 8'hFE;
    send_seq('{8'hE0, 8'hE0, 8'h74});
    expect_out("crsr_r_make", 8'hFE, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hE0, 8'hF0, 8'h74});
    expect_out("crsr_r_break", 8'hFE, 8'hFF, 1'b1, 1'b0);

    // Prefix still pending well before the timeout
    send(8'hE0);
    repeat (TO / 2) @(posedge clk);
    send(8'h74);
    expect_out("ext_before_timeout", 8'hFE, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hE0, 8'hF0, 8'h74});

    // Prefix abandoned after the timeout: 1C is plain A
    send(8'hE0);
    repeat (TO) @(posedge clk);
    send(8'h1C);
    pa_out = 8'hFD;
    expect_out("timeout_then_a", 8'hFD, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hF0, 8'h1C});

    // Self-test byte clears everything
    pa_out = 8'h00;
    send_seq('{8'h12, 8'h29, 8'h5A});
    expect_out("three_keys", 8'h00, 8'h6D, 1'b1, 1'b1);
    send(8'hAA);
    expect_out("aa_clear", 8'h00, 8'hFF, 1'b1, 1'b0);
    send(8'h1C);
    send(8'hFF);
    expect_out("ff_clear", 8'h00, 8'hFF, 1'b1, 1'b0);

    // kbd_clear beats a simultaneous byte and releases RESTORE
    send_seq('{8'hE0, 8'h7D, 8'h12});
    expect_out("before_clear", 8'h00, 8'h7F, 1'b0, 1'b1);
    @(posedge clk); #1;
    kbd_clear = 1'b1; ps2_valid = 1'b1; ps2_data = 8'h1C;
    @(posedge clk); #1;
    kbd_clear = 1'b0; ps2_valid = 1'b0; ps2_data = 8'h00;
    expect_out("kbd_clear_wins", 8'h00, 8'hFF, 1'b1, 1'b0);
    send(8'h1C);
    expect_out("make_after_clear", 8'h00, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hF0, 8'h1C});

    // Pause/Break sequence carries no key state
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
    expect_out("pause_then_a", 8'h00, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hF0, 8'h1C});
    // Exactly seven skipped bytes, all of them mapped keys
    send_seq('{8'hE1, 8'h12, 8'h29, 8'h5A, 8'h66, 8'h11, 8'h0D, 8'h76});
    expect_out("pause_skip_seven", 8'h00, 8'hFF, 1'b1, 1'b0);
    send(8'h1C);
    expect_out("after_skip_make", 8'h00, 8'hFB, 1'b1, 1'b1);
    send_seq('{8'hF0, 8'h1C});

    // Reset mid-sequence (after a break prefix)
    send_seq('{8'h12, 8'hF0});
    @(posedge clk); #1 reset = 1'b1;
    expect_out("reset_mid_seq", 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    send(8'h1C);
    expect_out("make_after_reset", 8'h00, 8'hFB, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
